// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and constants for the elevator car FSM and request scheduler
package elevator_pkg;

    localparam int FLOOR_W = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef logic [FLOOR_W-1:0] floor_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_DWELL = 2'd2
    } sched_state_e;

endpackage

// File: rtl/elevator_request_scheduler_floor_select.sv
// rtl/elevator_request_scheduler_floor_select.sv - SCAN target selection over the pending-call bitmap
//
// Purpose: purely combinational; picks the next floor to serve from the pending set,
// preferring the current direction of travel and reversing only when nothing lies ahead.
// Ports:
//   pending       in  NUM_FLOORS  outstanding-call bitmap
//   current_floor in  FLOOR_W     car position
//   dir_up        in  1           direction memory (1=up)
//   hit_here      out 1           a call is pending at current_floor
//   found         out 1           a call is pending above or below current_floor
//   sel_floor     out FLOOR_W     chosen target (nearest in travel direction, else nearest behind)
//   new_dir_up    out 1           direction after the choice
module floor_select #(
    parameter int NUM_FLOORS = 10,
    parameter int FLOOR_W    = 4
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  dir_up,
    output logic                  hit_here,
    output logic                  found,
    output logic [FLOOR_W-1:0]    sel_floor,
    output logic                  new_dir_up
);
    import elevator_pkg::*;

    logic               has_above;
    logic               has_below;
    logic [FLOOR_W-1:0] above;
    logic [FLOOR_W-1:0] below;

    always_comb begin
        has_above = 1'b0;
        has_below = 1'b0;
        above     = '0;
        below     = '0;
        hit_here  = 1'b0;
        // Scanning downward leaves the lowest floor above the car as the last winner.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) > current_floor)) begin
                has_above = 1'b1;
                above     = FLOOR_W'(i);
            end
        end
        // Scanning upward leaves the highest floor below the car as the last winner.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) < current_floor)) begin
                has_below = 1'b1;
                below     = FLOOR_W'(i);
            end
            if (pending[i] && (FLOOR_W'(i) == current_floor)) begin
                hit_here = 1'b1;
            end
        end
    end

    always_comb begin
        found      = has_above | has_below;
        sel_floor  = '0;
        new_dir_up = dir_up;
        if (dir_up == DIR_UP) begin
            if (has_above) begin
                sel_floor = above;
            end else if (has_below) begin
                sel_floor  = below;
                new_dir_up = DIR_DOWN;
            end
        end else begin
            if (has_below) begin
                sel_floor = below;
            end else if (has_above) begin
                sel_floor  = above;
                new_dir_up = DIR_UP;
            end
        end
    end

endmodule

// File: rtl/elevator_request_scheduler.sv
// rtl/elevator_request_scheduler.sv - collects floor calls and dispatches SCAN-ordered targets to the car FSM
//
// Purpose: holds the pending-call set, issues one target at a time, runs the door dwell and
// keeps direction memory. Optional return-to-home timeout under ELEVATOR_SCHED_HOME_EN.
// Ports:
//   clk, reset (async, active-high)
//   call_valid/call_floor  in   one-cycle call strobe and floor
//   current_floor/car_idle in   car position and idle status from the car FSM
//   target_floor/target_valid out  registered dispatch to the car FSM
//   dir_up    out  direction memory (1=up)
//   door_open out  high for DWELL_CYCLES cycles per stop
//   pending   out  registered outstanding-call bitmap
module elevator_request_scheduler #(
    parameter int NUM_FLOORS   = 10,
    parameter int FLOOR_W      = elevator_pkg::FLOOR_W,
    parameter int DWELL_CYCLES = 16,
    parameter int HOME_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  car_idle,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic                  dir_up,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);
    import elevator_pkg::*;

    localparam int DW_W = $clog2(DWELL_CYCLES + 1);

    if (DWELL_CYCLES < 1) begin : g_bad_dwell
        $error("DWELL_CYCLES must be at least 1");
    end
    if (HOME_TIMEOUT < 1) begin : g_bad_home
        $error("HOME_TIMEOUT must be at least 1");
    end
    if (NUM_FLOORS > 16 || NUM_FLOORS > (1 << FLOOR_W)) begin : g_bad_floors
        $error("NUM_FLOORS exceeds supported range");
    end

    sched_state_e          state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    target_floor_q, target_floor_d;
    logic                  target_valid_q, target_valid_d;
    logic                  dir_up_q, dir_up_d;
    logic                  door_open_q, door_open_d;
    logic [DW_W-1:0]       dwell_cnt_q, dwell_cnt_d;

    logic                  call_cap;
    logic                  set_en;
    logic                  clr_en;
    logic [FLOOR_W-1:0]    clr_floor;

    logic                  hit_here;
    logic                  found;
    logic [FLOOR_W-1:0]    sel_floor;
    logic                  new_dir_up;

`ifdef ELEVATOR_SCHED_HOME_EN
    localparam int HC_W = $clog2(HOME_TIMEOUT + 1);
    logic [HC_W-1:0] home_cnt_q, home_cnt_d;
    logic            home_move_q, home_move_d;
`endif

    floor_select #(
        .NUM_FLOORS(NUM_FLOORS),
        .FLOOR_W   (FLOOR_W)
    ) u_floor_select (
        .pending      (pending_q),
        .current_floor(current_floor),
        .dir_up       (dir_up_q),
        .hit_here     (hit_here),
        .found        (found),
        .sel_floor    (sel_floor),
        .new_dir_up   (new_dir_up)
    );

    // Extra MSB so NUM_FLOORS == 2**FLOOR_W does not wrap to zero.
    assign call_cap = call_valid && ({1'b0, call_floor} < (FLOOR_W + 1)'(NUM_FLOORS));
    // The car is standing at an open door: a call for this floor is already being served.
    assign set_en   = call_cap && !((state_q == ST_DWELL) && (call_floor == current_floor));

    always_comb begin
        state_d        = state_q;
        target_floor_d = target_floor_q;
        target_valid_d = target_valid_q;
        dir_up_d       = dir_up_q;
        door_open_d    = door_open_q;
        dwell_cnt_d    = dwell_cnt_q;
        clr_en         = 1'b0;
        clr_floor      = current_floor;
`ifdef ELEVATOR_SCHED_HOME_EN
        home_cnt_d     = '0;
        home_move_d    = home_move_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    if (hit_here) begin
                        clr_en      = 1'b1;
                        clr_floor   = current_floor;
                        state_d     = ST_DWELL;
                        door_open_d = 1'b1;
                        dwell_cnt_d = '0;
                    end else if (found) begin
                        target_floor_d = sel_floor;
                        target_valid_d = 1'b1;
                        dir_up_d       = new_dir_up;
                        state_d        = ST_MOVE;
                    end
                end
`ifdef ELEVATOR_SCHED_HOME_EN
                else if ((current_floor != '0) && !call_cap) begin
                    if (home_cnt_q == HC_W'(HOME_TIMEOUT - 1)) begin
                        target_floor_d = '0;
                        target_valid_d = 1'b1;
                        dir_up_d       = DIR_DOWN;
                        home_move_d    = 1'b1;
                        state_d        = ST_MOVE;
                    end else begin
                        home_cnt_d = home_cnt_q + 1'b1;
                    end
                end
`endif
            end
            ST_MOVE: begin
                if (car_idle && (current_floor == target_floor_q)) begin
                    target_valid_d = 1'b0;
`ifdef ELEVATOR_SCHED_HOME_EN
                    if (home_move_q) begin
                        home_move_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else
`endif
                    begin
                        clr_en      = 1'b1;
                        clr_floor   = target_floor_q;
                        state_d     = ST_DWELL;
                        door_open_d = 1'b1;
                        dwell_cnt_d = '0;
                    end
                end
            end
            ST_DWELL: begin
                if (dwell_cnt_q >= DW_W'(DWELL_CYCLES - 1)) begin
                    state_d     = ST_IDLE;
                    door_open_d = 1'b0;
                    dwell_cnt_d = '0;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A call and a clear on the same floor: the clear wins only when the car is standing there.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (clr_en && (FLOOR_W'(i) == clr_floor)) begin
                pending_d[i] = 1'b0;
            end
            if (set_en && (FLOOR_W'(i) == call_floor)
                && !(clr_en && (clr_floor == call_floor) && (call_floor == current_floor))) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            pending_q      <= '0;
            target_floor_q <= '0;
            target_valid_q <= 1'b0;
            dir_up_q       <= DIR_UP;
            door_open_q    <= 1'b0;
            dwell_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            target_floor_q <= target_floor_d;
            target_valid_q <= target_valid_d;
            dir_up_q       <= dir_up_d;
            door_open_q    <= door_open_d;
            dwell_cnt_q    <= dwell_cnt_d;
        end
    end

`ifdef ELEVATOR_SCHED_HOME_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            home_cnt_q  <= '0;
            home_move_q <= 1'b0;
        end else begin
            home_cnt_q  <= home_cnt_d;
            home_move_q <= home_move_d;
        end
    end
`endif

    assign target_floor = target_floor_q;
    assign target_valid = target_valid_q;
    assign dir_up       = dir_up_q;
    assign door_open    = door_open_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// tb/tb_elevator_request_scheduler.sv - self-checking bench for elevator_request_scheduler
module tb_elevator_request_scheduler;

    localparam int NF = 10;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          call_valid = 1'b0;
    logic [3:0]    call_floor = '0;
    logic [3:0]    current_floor = '0;
    logic          car_idle = 1'b1;
    logic [3:0]    target_floor;
    logic          target_valid;
    logic          dir_up;
    logic          door_open;
    logic [NF-1:0] pending;

    int total = 0;
    int bad   = 0;

    // Reference model: pending set, a mode (0 idle, 1 moving, 2 doors open) and a countdown.
    bit [NF-1:0] m_pend;
    int          m_mode;
    int          m_tgt;
    int          m_timer;
    bit          m_tv;
    bit          m_dir;

    elevator_request_scheduler #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (4),
        .DWELL_CYCLES(D),
        .HOME_TIMEOUT(64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .call_valid   (call_valid),
        .call_floor   (call_floor),
        .current_floor(current_floor),
        .car_idle     (car_idle),
        .target_floor (target_floor),
        .target_valid (target_valid),
        .dir_up       (dir_up),
        .door_open    (door_open),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend = '0; m_mode = 0; m_tgt = 0; m_timer = 0; m_tv = 0; m_dir = 1;
    endtask

    task automatic model_edge();
        int  cur;
        int  cf;
        int  clr;
        int  up;
        int  dn;
        bit  was_open;
        cur = int'(current_floor);
        cf  = int'(call_floor);
        clr = -1;
        was_open = (m_mode == 2);
        if (m_mode == 0) begin
            if (m_pend != 0) begin
                if (cur < NF && m_pend[cur]) begin
                    m_pend[cur] = 0; clr = cur; m_mode = 2; m_timer = D;
                end else begin
                    up = -1; dn = -1;
                    for (int f = 0; f < NF; f++) begin
                        if (m_pend[f] && f > cur && up < 0) up = f;
                        if (m_pend[f] && f < cur) dn = f;
                    end
                    if (m_dir) begin
                        if (up >= 0) m_tgt = up; else begin m_tgt = dn; m_dir = 0; end
                    end else begin
                        if (dn >= 0) m_tgt = dn; else begin m_tgt = up; m_dir = 1; end
                    end
                    m_tv = 1; m_mode = 1;
                end
            end
        end else if (m_mode == 1) begin
            if (car_idle && cur == m_tgt) begin
                m_pend[m_tgt] = 0; clr = m_tgt; m_tv = 0; m_mode = 2; m_timer = D;
            end
        end else begin
            m_timer = m_timer - 1;
            if (m_timer == 0) m_mode = 0;
        end
        if (call_valid && cf < NF && !(was_open && cf == cur) && !(clr == cf && cf == cur))
            m_pend[cf] = 1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic call(input int f);
        call_valid = 1'b1;
        call_floor = 4'(f);
        step();
        call_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        call_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_door_low(output int n);
        n = 0;
        for (int k = 0; k < 40 && door_open === 1'b1; k++) begin
            step();
            if (door_open === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        total++; if (target_floor !== 4'd0) begin bad++; $display("FAIL reset_tf act=%0d exp=0", target_floor); end
        total++; if (target_valid !== 1'b0) begin bad++; $display("FAIL reset_tv act=%0b exp=0", target_valid); end
        total++; if (dir_up !== 1'b1) begin bad++; $display("FAIL reset_dir act=%0b exp=1", dir_up); end
        total++; if (door_open !== 1'b0) begin bad++; $display("FAIL reset_door act=%0b exp=0", door_open); end
        total++; if (pending !== '0) begin bad++; $display("FAIL reset_pend act=%b exp=0", pending); end
    endtask

    task automatic test_basic_dispatch();
        int n;
        do_reset();
        current_floor = 4'd0; car_idle = 1'b1;
        call(3);
        total++; if (pending !== 10'h008) begin bad++; $display("FAIL basic_pend act=%b exp=%b", pending, 10'h008); end
        total++; if (target_valid !== 1'b0) begin bad++; $display("FAIL basic_early_tv act=%0b exp=0", target_valid); end
        step();
        total++; if ({target_valid, target_floor} !== {1'b1, 4'd3}) begin bad++; $display("FAIL basic_dispatch act=%0b/%0d exp=1/3", target_valid, target_floor); end
        current_floor = 4'd3;
        step();
        total++; if ({door_open, target_valid, pending} !== {1'b1, 1'b0, 10'h0}) begin bad++; $display("FAIL basic_arrive act=%0b/%0b/%b exp=1/0/0", door_open, target_valid, pending); end
        wait_door_low(n);
        total++; if (n + 1 != D || door_open !== 1'b0) begin bad++; $display("FAIL basic_dwell_len act=%0d exp=%0d", n + 1, D); end
    endtask

    task automatic test_scan_order();
        int n;
        do_reset();
        current_floor = 4'd5; car_idle = 1'b1;
        call(5);
        step();
        call(2);
        call(7);
        total++; if (pending !== 10'h084) begin bad++; $display("FAIL scan_pend act=%b exp=%b", pending, 10'h084); end
        wait_door_low(n);
        total++; if (target_valid !== 1'b0) begin bad++; $display("FAIL scan_no_early act=%0b exp=0", target_valid); end
        step();
        total++; if ({target_valid, target_floor, dir_up} !== {1'b1, 4'd7, 1'b1}) begin bad++; $display("FAIL scan_first act=%0b/%0d/%0b exp=1/7/1", target_valid, target_floor, dir_up); end
        current_floor = 4'd7;
        step();
        wait_door_low(n);
        step();
        total++; if ({target_valid, target_floor, dir_up} !== {1'b1, 4'd2, 1'b0}) begin bad++; $display("FAIL scan_second act=%0b/%0d/%0b exp=1/2/0", target_valid, target_floor, dir_up); end
    endtask

    task automatic test_own_floor();
        int n;
        do_reset();
        current_floor = 4'd4; car_idle = 1'b1;
        call(4);
        total++; if ({door_open, pending} !== {1'b0, 10'h010}) begin bad++; $display("FAIL own_first act=%0b/%b exp=0/%b", door_open, pending, 10'h010); end
        step();
        total++; if ({door_open, target_valid, pending} !== {1'b1, 1'b0, 10'h0}) begin bad++; $display("FAIL own_open act=%0b/%0b/%b exp=1/0/0", door_open, target_valid, pending); end
        n = 1;
        call(4);
        if (door_open === 1'b1) n++;
        total++; if (pending !== 10'h0) begin bad++; $display("FAIL own_absorb act=%b exp=0", pending); end
        begin
            int rest;
            wait_door_low(rest);
            n = n + rest;
        end
        total++; if (n != D) begin bad++; $display("FAIL own_dwell_len act=%0d exp=%0d", n, D); end
    endtask

    task automatic test_range_and_freeze();
        int n;
        do_reset();
        current_floor = 4'd0; car_idle = 1'b1;
        call(12);
        total++; if (pending !== 10'h0) begin bad++; $display("FAIL range_pend act=%b exp=0", pending); end
        step();
        total++; if (target_valid !== 1'b0) begin bad++; $display("FAIL range_tv act=%0b exp=0", target_valid); end
        call(8);
        step();
        current_floor = 4'd3; car_idle = 1'b0;
        call(6);
        current_floor = 4'd6; car_idle = 1'b1;
        step();
        total++; if ({target_valid, target_floor, pending} !== {1'b1, 4'd8, 10'h140}) begin bad++; $display("FAIL freeze act=%0b/%0d/%b exp=1/8/%b", target_valid, target_floor, pending, 10'h140); end
        current_floor = 4'd8;
        step();
        total++; if ({door_open, pending} !== {1'b1, 10'h040}) begin bad++; $display("FAIL freeze_arrive act=%0b/%b exp=1/%b", door_open, pending, 10'h040); end
        wait_door_low(n);
        step();
        total++; if ({target_valid, target_floor, dir_up} !== {1'b1, 4'd6, 1'b0}) begin bad++; $display("FAIL freeze_next act=%0b/%0d/%0b exp=1/6/0", target_valid, target_floor, dir_up); end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        current_floor = 4'd0; car_idle = 1'b1;
        call(6);
        step();
        current_floor = 4'd2; car_idle = 1'b0;
        call(3);
        total++; if ({target_valid, pending} !== {1'b1, 10'h048}) begin bad++; $display("FAIL mid_setup act=%0b/%b exp=1/%b", target_valid, pending, 10'h048); end
        #3 reset = 1'b1;
        #1;
        total++; if ({target_floor, target_valid, dir_up, door_open, pending} !== {4'd0, 1'b0, 1'b1, 1'b0, 10'h0})
            begin bad++; $display("FAIL mid_reset act=%0d/%0b/%0b/%0b/%b exp=0/0/1/0/0", target_floor, target_valid, dir_up, door_open, pending); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        car_idle = 1'b1;
        for (int k = 0; k < 5; k++) step();
        total++; if ({target_valid, pending} !== {1'b0, 10'h0}) begin bad++; $display("FAIL mid_after act=%0b/%b exp=0/0", target_valid, pending); end
    endtask

    task automatic test_random();
        int car_pos;
        logic [17:0] exp_v;
        logic [17:0] act_v;
        do_reset();
        car_pos = 0;
        current_floor = 4'd0; car_idle = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            call_valid = ($urandom_range(0, 99) < 15);
            call_floor = 4'($urandom_range(0, 13));
            if (m_tv && car_pos != m_tgt) begin
                car_idle = 1'b0;
                if ($urandom_range(0, 2) == 0) car_pos = car_pos + ((m_tgt > car_pos) ? 1 : -1);
            end else begin
                car_idle = ($urandom_range(0, 3) != 0);
            end
            current_floor = 4'(car_pos);
            step();
            exp_v = {4'(m_tgt), m_tv, m_dir, (m_mode == 2), m_pend};
            act_v = {target_floor, target_valid, dir_up, door_open, pending};
            total++;
            if (act_v !== exp_v) begin bad++; $display("FAIL random cyc=%0d act=%h exp=%h", c, act_v, exp_v); end
        end
        call_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_dispatch();
        test_scan_order();
        test_own_floor();
        test_range_and_freeze();
        test_reset_mid_move();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_request_scheduler.md
# elevator_request_scheduler

Collects floor calls from the cabin/hall buttons into a pending set and issues one target floor at a time to the elevator car FSM using SCAN (elevator) ordering. It controls door dwell and direction memory. It sits between the button inputs on `ui_in` and the car FSM's `requested_floor` input, and reads back the car's `current_floor` and idle status.

## Interface
- `NUM_FLOORS`, default 10: floors 0..NUM_FLOORS-1; must be ≤ 16.
- `FLOOR_W`, default 4: width of floor numbers.
- `DWELL_CYCLES`, default 16: number of door-open cycles per stop; must be ≥ 1.
- `HOME_TIMEOUT`, default 64: number of idle cycles before a return home; used only with `ELEVATOR_SCHED_HOME_EN`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `call_valid` in 1: one-cycle call strobe.
- `call_floor` in FLOOR_W: floor being called; sampled when `call_valid`=1.
- `current_floor` in FLOOR_W: car position, from the car FSM.
- `car_idle` in 1: car FSM is in IDLE (not moving).
- `target_floor` out FLOOR_W: floor the car must go to; drives `requested_floor`.
- `target_valid` out 1: `target_floor` is an active dispatch.
- `dir_up` out 1: direction memory (1=up, 0=down).
- `door_open` out 1: high during dwell.
- `pending` out NUM_FLOORS: registered outstanding-call bitmap.

## Operation
- States: IDLE, MOVE, DWELL.
- Call capture: if `call_valid` and `call_floor` < NUM_FLOORS, set `pending[call_floor]` at the clock edge. Out-of-range calls are dropped silently. Duplicate calls are idempotent.
- IDLE, with `pending` nonzero:
  - If `pending[current_floor]` is set: clear that bit and go to DWELL. No dispatch is issued.
  - Otherwise, if `dir_up`: when any bit is above `current_floor`, target the lowest set floor above it and go to MOVE. Else target the highest set floor below it, clear `dir_up`, and go to MOVE.
  - The downward case is symmetric.
  - On entering MOVE, register `target_floor` and set `target_valid`.
- MOVE:
  - `target_floor` is frozen. Calls are captured but never retarget mid-move.
  - Arrival is `car_idle && current_floor == target_floor`. On arrival: clear `pending[target_floor]`, drop `target_valid`, and go to DWELL.
- DWELL:
  - `door_open`=1 for exactly DWELL_CYCLES cycles, then go to IDLE.
  - A call for `current_floor` during DWELL is absorbed: the bit is not set and the dwell is not extended.
- Simultaneous events: a call is captured on the same edge that clears the same floor's bit. If that floor equals `current_floor`, the clear wins. Otherwise the set wins.
- IDLE with `pending`=0: hold. `target_floor` keeps its last value and `target_valid`=0.
- Dwell counter width is $clog2(DWELL_CYCLES+1). The counter saturates and does not wrap.

## Timing
- Reset values: state=IDLE, `pending`=0, `target_floor`=0, `target_valid`=0, `dir_up`=1, `door_open`=0. All counters are 0.
- Reset mid-move or mid-dwell: all state is lost immediately, including pending calls.
- Latency from a call at edge N (car idle, different floor): `pending` is visible after N, and `target_valid`=1 after edge N+1.
- Latency for a call at the car's own floor: `door_open`=1 after edge N+1.
- Arrival detected at edge A: `target_valid`=0 and `door_open`=1 after A. `door_open` falls after edge A+DWELL_CYCLES.
- The next dispatch can issue on the edge after `door_open` falls.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `ELEVATOR_SCHED_HOME_EN`.
- Defined: in IDLE with `pending`=0 and `current_floor`≠0 for HOME_TIMEOUT consecutive cycles, issue a dispatch to floor 0 and clear `dir_up`.
  - Arrival completes with no DWELL and no pending change.
  - Any call captured during the timeout restarts the count.
  - Home dispatches are frozen like normal moves.
- Undefined: the car stays at its last floor indefinitely. The timeout counter is not instantiated.

## Structure
- Shared package `elevator_pkg` holds:
  - the state enum (IDLE/MOVE/DWELL)
  - the `FLOOR_W` localparam
  - direction constants
  - the 7-segment-independent floor type
- The car FSM and this block both use `elevator_pkg`.
- Sub-module `floor_select` (combinational) takes `pending`, `current_floor` and `dir_up`. It returns `hit_here`, `found`, `sel_floor` and `new_dir_up`.
  - It contains the nearest-above and nearest-below priority scans.
  - It is verified standalone.

## Test plan
- Reset, then car idle at floor 0, then a call to floor 3 → `target_valid`=1 and `target_floor`=3 two edges later. Set `current_floor`=3 with `car_idle` → `door_open` high for 16 cycles and `pending`=0.
- Car at floor 5, `dir_up`=1, calls to 2 and 7 → dispatch 7 first. After its dwell, dispatch 2 with `dir_up`=0.
- Car idle at floor 4, call to 4 → no dispatch and `door_open`=1 one edge later. A second call to 4 during dwell is absorbed and `pending[4]` stays 0.
- Call to floor 12 with NUM_FLOORS=10 → `pending` unchanged and no dispatch. Call to floor 6 during MOVE to 8 → target stays 8, and 6 is dispatched after the dwell at 8.
- Assert `reset` mid-MOVE with `pending`=8'b0100_1000 → all outputs at reset values within the same cycle, with no further dispatch.
- With `ELEVATOR_SCHED_HOME_EN`, car at 5 with no calls → after 64 cycles `target_floor`=0, `target_valid`=1, and no dwell on arrival.
